// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: round FSM, move-tick timer, direction arbitration, round-start reset pulse.
// Optional macro SPEED_UP_EN: the move period shrinks with score level, down to TICK_MIN.
module snake_game_ctrl #(
    parameter int unsigned TICK_BASE   = 250_000,
    parameter int unsigned TICK_STEP   = 20_000,
    parameter int unsigned TICK_MIN    = 100_000,
    parameter int unsigned LEVEL_SHIFT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_pause,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       hit_wall,
    input  logic       hit_body,
    input  logic [7:0] score,
    output logic [1:0] game_state,
    output logic       move_tick,
    output logic [1:0] dir,
    output logic       game_rst
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    state_t      state, state_n;
    logic [31:0] counter, counter_n;
    logic [31:0] period;
    logic [1:0]  pending_dir, pending_n, dir_n, cand;
    logic        move_tick_n, game_rst_n;
    logic        start_q, start_prev, pause_q, pause_prev;
    logic        start_edge, pause_edge, key_any, tick_due;

    assign start_edge = start_q & ~start_prev;
    assign pause_edge = pause_q & ~pause_prev;
    assign key_any    = key_up | key_down | key_left | key_right;

`ifdef SPEED_UP_EN
    logic [31:0] step_total;
    assign step_total = (32'(score) >> LEVEL_SHIFT) * TICK_STEP;
    // Compare before subtracting so the period never underflows below the floor.
    assign period = (step_total >= TICK_BASE - TICK_MIN) ? TICK_MIN : TICK_BASE - step_total;
`else
    logic unused_cfg;
    assign unused_cfg = ^{score, TICK_STEP, TICK_MIN, LEVEL_SHIFT};
    assign period     = TICK_BASE;
`endif

    // >= rather than == so a period that shrinks mid-count fires at once instead of wrapping.
    assign tick_due = counter >= period - 32'd1;

    always_comb begin
        cand = DIR_RIGHT;
        if (key_up)        cand = DIR_UP;
        else if (key_down) cand = DIR_DOWN;
        else if (key_left) cand = DIR_LEFT;
    end

    always_comb begin
        state_n     = state;
        counter_n   = counter;
        dir_n       = dir;
        pending_n   = pending_dir;
        move_tick_n = 1'b0;
        game_rst_n  = 1'b0;
        case (state)
            IDLE, OVER: begin
                if (start_edge) begin
                    game_rst_n = 1'b1;
                    dir_n      = DIR_RIGHT;
                    pending_n  = DIR_RIGHT;
                    counter_n  = '0;
                    state_n    = PLAY;
                end
            end
            PLAY: begin
                if (key_any && cand != (dir ^ 2'd1))
                    pending_n = cand;
                if (hit_wall || hit_body) begin
                    state_n = OVER;
                end else if (pause_edge) begin
                    state_n = PAUSE;
                end else if (tick_due) begin
                    move_tick_n = 1'b1;
                    counter_n   = '0;
                    dir_n       = pending_dir;
                end else begin
                    counter_n = counter + 32'd1;
                end
            end
            PAUSE: begin
                if (pause_edge)
                    state_n = PLAY;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            counter     <= '0;
            dir         <= DIR_RIGHT;
            pending_dir <= DIR_RIGHT;
            move_tick   <= 1'b0;
            game_rst    <= 1'b0;
            start_q     <= 1'b0;
            start_prev  <= 1'b0;
            pause_q     <= 1'b0;
            pause_prev  <= 1'b0;
        end else begin
            state       <= state_n;
            counter     <= counter_n;
            dir         <= dir_n;
            pending_dir <= pending_n;
            move_tick   <= move_tick_n;
            game_rst    <= game_rst_n;
            start_q     <= key_start;
            start_prev  <= start_q;
            pause_q     <= key_pause;
            pause_prev  <= pause_q;
        end
    end

    assign game_state = state;

endmodule
